dds_phase_acc_a: RTL and testbench
==================================

Name: dds_phase_acc_a

Overview:
DDS phase accumulator for channel A. It sits directly upstream of the channel-A waveform ROM/select stage and drives that stage's 10-bit ROM address (phase) input.
- Frequency tuning word (FTW) and phase offset are written over the STM32 bus (CS/WR_EN/ADDR/DATA) into shadow registers.
- Shadow values are committed atomically, so a 32-bit FTW never applies half-updated.
- All bus capture is synchronous to CLK; the block contains no latches.

Parameters:
ADDR_FTW_L, 16'h0008, bus address of FTW[15:0] shadow
ADDR_FTW_H, 16'h0009, bus address of FTW[31:16] shadow
ADDR_POFF, 16'h000A, bus address of 16-bit phase offset shadow
ADDR_CTRL, 16'h000B, bus address of control word
ACC_W, 32, accumulator width
OUT_W, 10, output phase width (ROM depth 1024)

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous reset, active-high
CS  in  1  chip select, active-low
WR_EN  in  1  write enable, active-high
ADDR  in  16  bus address
DATA  in  16  bus write data
addr_a  out  OUT_W  phase/ROM address to the waveform stage
phase_valid  out  1  high while addr_a is advancing (RUN), aligned with addr_a
sync_pulse  out  1  one-cycle pulse on accumulator wrap, aligned with addr_a

Behaviour:
- Reset (async, RST=1): all of the following clear to 0: acc, ftw_act, ftw_shd, poff_act, poff_shd, run, commit_pend, addr_a, phase_valid, sync_pulse. State = IDLE.
- Bus write:
  - Occurs on posedge CLK when !CS && WR_EN.
  - ADDR_FTW_L/H/POFF writes update only the shadow registers.
  - Writes to any other address are ignored.
- CTRL write bits:
  - bit0: run (level, stored).
  - bit1: commit (self-clearing; sets commit_pend).
  - bit2: phase_clear (self-clearing).
  - Other bits are ignored.
- Commit:
  - The cycle after a commit write, ftw_act<=ftw_shd, poff_act<=poff_shd, and commit_pend clears.
  - Shadow writes landing in that same following cycle are not included.
- State machine:
  - IDLE: acc holds.
  - IDLE->RUN when run=1.
  - RUN: acc <= acc + ftw_act (mod 2^ACC_W) every cycle.
  - RUN->IDLE when run=0; acc holds its last value.
- Phase clear:
  - Sets acc<=0 in the cycle after the write, in either state.
  - If commit is written in the same write, the clear and the new FTW apply in the same cycle.
  - The first increment then uses the new ftw_act.
- Output:
  - sum = acc + {poff_act, 16'h0000} (mod 2^ACC_W).
  - addr_a <= sum[ACC_W-1 -: OUT_W], registered: 1 cycle after acc.
  - Offset is applied even in IDLE, so addr_a reflects a committed offset while held.
- sync_pulse: registered carry-out of acc+ftw_act in RUN, delayed to align with addr_a. Never asserted in IDLE or on phase_clear.
- phase_valid: (state==RUN) delayed 1 cycle.
- FTW=0 in RUN: addr_a constant, phase_valid=1, no sync_pulse.
- Reset mid-run: outputs go to 0 immediately (async); restart requires run and commit writes again.

Decomposition:
- Shared package dds_pkg:
  - Bus address constants (0x0008–0x000B, alongside existing waveform select 0x000C).
  - ACC_W, OUT_W.
  - CTRL bit indices (CTRL_RUN=0, CTRL_COMMIT=1, CTRL_CLR=2).
  - State enum (IDLE, RUN).
- Single module; the bus shadow-register logic is small enough to stay inline, so no sub-module.
- A channel-B instance reuses this module with different address parameters.

Test Plan:
1. Write FTW_L=0x0000, FTW_H=0x0040 (FTW=2^22), commit, run=1 -> addr_a counts 0,1,2… one per clock; sync_pulse exactly once per 1024 cycles, coincident with addr_a going 1023->0.
2. While running, write FTW_H=0x0080 without commit -> step stays 1. Then write commit -> step becomes 2 starting 2 cycles after the commit write; no intermediate step value appears.
3. POFF=0x4000, commit, run=0, acc=0 -> addr_a=256 held; phase_valid=0; sync_pulse=0.
4. Running with FTW=2^22; write CTRL=0x7 (run|commit|clear) with FTW_H shadow=0x0100 -> addr_a sequence restarts 0,4,8,…
5. Assert RST for 1 cycle mid-run at addr_a=500 -> addr_a=0, phase_valid=0 immediately. After release, no advance until run and commit are rewritten.
6. Write with CS=1 or an unmapped ADDR=0x000C -> no shadow or control change; addr_a trajectory is unchanged.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared constants, control-word bit indices and state type for the DDS phase
// accumulator channels and their bus register map.
package dds_pkg;

    localparam logic [15:0] ADDR_FTW_L = 16'h0008;
    localparam logic [15:0] ADDR_FTW_H = 16'h0009;
    localparam logic [15:0] ADDR_POFF  = 16'h000A;
    localparam logic [15:0] ADDR_CTRL  = 16'h000B;
    localparam logic [15:0] ADDR_WSEL  = 16'h000C;

    localparam int ACC_W = 32;
    localparam int OUT_W = 10;

    localparam int CTRL_RUN    = 0;
    localparam int CTRL_COMMIT = 1;
    localparam int CTRL_CLR    = 2;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // The ROM address is the top OUT_W bits of the offset phase.
    function automatic logic [OUT_W-1:0] phase_index(input logic [ACC_W-1:0] phase);
        return phase[ACC_W-1 -: OUT_W];
    endfunction

endpackage

// File: rtl/dds_phase_acc_a.sv
// Channel-A DDS phase accumulator: bus-written shadow FTW/offset with atomic
// commit, run/idle control and a registered ROM address with wrap pulse.
module dds_phase_acc_a
    import dds_pkg::*;
#(
    parameter logic [15:0] P_ADDR_FTW_L = ADDR_FTW_L,
    parameter logic [15:0] P_ADDR_FTW_H = ADDR_FTW_H,
    parameter logic [15:0] P_ADDR_POFF  = ADDR_POFF,
    parameter logic [15:0] P_ADDR_CTRL  = ADDR_CTRL
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CS,
    input  logic             WR_EN,
    input  logic [15:0]      ADDR,
    input  logic [15:0]      DATA,
    output logic [OUT_W-1:0] addr_a,
    output logic             phase_valid,
    output logic             sync_pulse
);

    logic             wr_s;
    logic [ACC_W-1:0] ftw_shd_q, ftw_shd_d, ftw_act_q, ftw_act_d;
    logic [15:0]      poff_shd_q, poff_shd_d, poff_act_q, poff_act_d;
    logic             run_q, run_d;
    logic             commit_pend_q, commit_pend_d;
    logic             clr_pend_q, clr_pend_d;
    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d, acc_inc_s, sum_s;
    logic             carry_s, carry_q, carry_d;
    logic [OUT_W-1:0] addr_q, addr_d;
    logic             valid_q, valid_d;
    logic             sync_q, sync_d;

    assign wr_s = !CS && WR_EN;

    // Bus decode: shadows and control bits; commit/clear live for one cycle only.
    always_comb begin
        ftw_shd_d     = ftw_shd_q;
        poff_shd_d    = poff_shd_q;
        run_d         = run_q;
        commit_pend_d = 1'b0;
        clr_pend_d    = 1'b0;
        if (wr_s) begin
            case (ADDR)
                P_ADDR_FTW_L: ftw_shd_d[15:0]  = DATA;
                P_ADDR_FTW_H: ftw_shd_d[31:16] = DATA;
                P_ADDR_POFF:  poff_shd_d       = DATA;
                P_ADDR_CTRL: begin
                    run_d         = DATA[CTRL_RUN];
                    commit_pend_d = DATA[CTRL_COMMIT];
                    clr_pend_d    = DATA[CTRL_CLR];
                end
                default: begin
                    run_d = run_q;
                end
            endcase
        end else begin
            run_d = run_q;
        end
    end

    // Active-register transfer taken a full cycle after the commit write.
    always_comb begin
        ftw_act_d  = ftw_act_q;
        poff_act_d = poff_act_q;
        if (commit_pend_q) begin
            ftw_act_d  = ftw_shd_q;
            poff_act_d = poff_shd_q;
        end else begin
            ftw_act_d  = ftw_act_q;
            poff_act_d = poff_act_q;
        end
    end

    // Run/idle sequencing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (run_q) state_d = RUN;
                else       state_d = IDLE;
            end
            RUN: begin
                if (run_q) state_d = RUN;
                else       state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Accumulator step; a pending clear wins and never reports a wrap.
    always_comb begin
        {carry_s, acc_inc_s} = {1'b0, acc_q} + {1'b0, ftw_act_q};
        acc_d   = acc_q;
        carry_d = 1'b0;
        if (clr_pend_q) begin
            acc_d   = {ACC_W{1'b0}};
            carry_d = 1'b0;
        end else if (state_q == RUN) begin
            acc_d   = acc_inc_s;
            carry_d = carry_s;
        end else begin
            acc_d   = acc_q;
            carry_d = 1'b0;
        end
    end

    // Output stage one cycle behind the accumulator; wrap flag realigned to it.
    always_comb begin
        sum_s   = acc_q + {poff_act_q, {(ACC_W-16){1'b0}}};
        addr_d  = phase_index(sum_s);
        valid_d = (state_q == RUN);
        sync_d  = carry_q;
    end

    // State and datapath registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ftw_shd_q     <= {ACC_W{1'b0}};
            ftw_act_q     <= {ACC_W{1'b0}};
            poff_shd_q    <= 16'h0000;
            poff_act_q    <= 16'h0000;
            run_q         <= 1'b0;
            commit_pend_q <= 1'b0;
            clr_pend_q    <= 1'b0;
            state_q       <= IDLE;
            acc_q         <= {ACC_W{1'b0}};
            carry_q       <= 1'b0;
            addr_q        <= {OUT_W{1'b0}};
            valid_q       <= 1'b0;
            sync_q        <= 1'b0;
        end else begin
            ftw_shd_q     <= ftw_shd_d;
            ftw_act_q     <= ftw_act_d;
            poff_shd_q    <= poff_shd_d;
            poff_act_q    <= poff_act_d;
            run_q         <= run_d;
            commit_pend_q <= commit_pend_d;
            clr_pend_q    <= clr_pend_d;
            state_q       <= state_d;
            acc_q         <= acc_d;
            carry_q       <= carry_d;
            addr_q        <= addr_d;
            valid_q       <= valid_d;
            sync_q        <= sync_d;
        end
    end

    assign addr_a      = addr_q;
    assign phase_valid = valid_q;
    assign sync_pulse  = sync_q;

endmodule

// File: tb/tb_dds_phase_acc_a.sv
// Directed bench for dds_phase_acc_a: counting, commit timing, idle offset,
// phase clear, mid-run reset and ignored bus cycles.
module tb_dds_phase_acc_a;

    logic        CLK;
    logic        RST;
    logic        CS;
    logic        WR_EN;
    logic [15:0] ADDR;
    logic [15:0] DATA;
    logic [9:0]  addr_a;
    logic        phase_valid;
    logic        sync_pulse;

    int tests;
    int fails;

    dds_phase_acc_a dut (
        .CLK         (CLK),
        .RST         (RST),
        .CS          (CS),
        .WR_EN       (WR_EN),
        .ADDR        (ADDR),
        .DATA        (DATA),
        .addr_a      (addr_a),
        .phase_valid (phase_valid),
        .sync_pulse  (sync_pulse)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Called 1 time unit after a rising edge; returns 1 unit after the next one.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic bus_write(input logic cs_n, input logic we, input logic [15:0] a, input logic [15:0] d);
        CS    = cs_n;
        WR_EN = we;
        ADDR  = a;
        DATA  = d;
        @(posedge CLK);
        #1;
        CS    = 1'b1;
        WR_EN = 1'b0;
        ADDR  = 16'h0000;
        DATA  = 16'h0000;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        CS = 1'b1; WR_EN = 1'b0; ADDR = 16'h0000; DATA = 16'h0000;
        step();
        tests++;
        if (addr_a !== 10'd0 || phase_valid !== 1'b0 || sync_pulse !== 1'b0) begin
            $display("FAIL reset_state: addr=%0d pv=%b sync=%b, required 0/0/0", addr_a, phase_valid, sync_pulse);
            fails++;
        end
        RST = 1'b0;
        step();
        tests++;
        if (addr_a !== 10'd0 || phase_valid !== 1'b0) begin
            $display("FAIL reset_release: addr=%0d pv=%b, required 0/0", addr_a, phase_valid);
            fails++;
        end
    endtask

    task automatic test_count();
        logic [9:0] ea;
        int nsync;
        bus_write(1'b0, 1'b1, 16'h0008, 16'h0000);
        bus_write(1'b0, 1'b1, 16'h0009, 16'h0040);
        bus_write(1'b0, 1'b1, 16'h000B, 16'h0003);
        tests++;
        if (addr_a !== 10'd0 || phase_valid !== 1'b0) begin
            $display("FAIL count_pre: addr=%0d pv=%b, required 0/0", addr_a, phase_valid);
            fails++;
        end
        step();
        step();
        tests++;
        if (addr_a !== 10'd0 || phase_valid !== 1'b1 || sync_pulse !== 1'b0) begin
            $display("FAIL count_start: addr=%0d pv=%b sync=%b, required 0/1/0", addr_a, phase_valid, sync_pulse);
            fails++;
        end
        nsync = 0;
        for (int i = 1; i <= 1024; i++) begin
            step();
            ea = 10'(i);
            if (sync_pulse === 1'b1) nsync++;
            tests++;
            if (addr_a !== ea || sync_pulse !== (i == 1024) || phase_valid !== 1'b1) begin
                $display("FAIL count_seq[%0d]: addr=%0d sync=%b pv=%b, required %0d/%b/1",
                         i, addr_a, sync_pulse, phase_valid, ea, (i == 1024));
                fails++;
            end
        end
        tests++;
        if (nsync != 1) begin
            $display("FAIL count_sync_total: got %0d pulses, required 1", nsync);
            fails++;
        end
    endtask

    task automatic test_commit();
        logic [9:0] exp_pre [3];
        logic [9:0] exp_post [6];
        exp_pre  = '{10'd1, 10'd2, 10'd3};
        exp_post = '{10'd4, 10'd5, 10'd6, 10'd8, 10'd10, 10'd12};
        bus_write(1'b0, 1'b1, 16'h0009, 16'h0080);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) step();
            tests++;
            if (addr_a !== exp_pre[i]) begin
                $display("FAIL shadow_only[%0d]: addr=%0d, required %0d", i, addr_a, exp_pre[i]);
                fails++;
            end
        end
        bus_write(1'b0, 1'b1, 16'h000B, 16'h0003);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) step();
            tests++;
            if (addr_a !== exp_post[i]) begin
                $display("FAIL commit_step[%0d]: addr=%0d, required %0d", i, addr_a, exp_post[i]);
                fails++;
            end
        end
    endtask

    task automatic test_offset_idle();
        bus_write(1'b0, 1'b1, 16'h000A, 16'h4000);
        bus_write(1'b0, 1'b1, 16'h000B, 16'h0006);
        step();
        for (int i = 0; i < 5; i++) begin
            step();
            tests++;
            if (addr_a !== 10'd256 || phase_valid !== 1'b0 || sync_pulse !== 1'b0) begin
                $display("FAIL idle_offset[%0d]: addr=%0d pv=%b sync=%b, required 256/0/0",
                         i, addr_a, phase_valid, sync_pulse);
                fails++;
            end
        end
    endtask

    task automatic test_clear();
        logic [9:0] exp_clr [6];
        exp_clr = '{10'd11, 10'd12, 10'd0, 10'd4, 10'd8, 10'd12};
        bus_write(1'b0, 1'b1, 16'h000A, 16'h0000);
        bus_write(1'b0, 1'b1, 16'h0009, 16'h0040);
        bus_write(1'b0, 1'b1, 16'h000B, 16'h0007);
        step();
        step();
        tests++;
        if (addr_a !== 10'd0 || phase_valid !== 1'b1) begin
            $display("FAIL clear_restart: addr=%0d pv=%b, required 0/1", addr_a, phase_valid);
            fails++;
        end
        for (int i = 1; i <= 9; i++) begin
            step();
            tests++;
            if (addr_a !== 10'(i)) begin
                $display("FAIL clear_run[%0d]: addr=%0d, required %0d", i, addr_a, i);
                fails++;
            end
        end
        bus_write(1'b0, 1'b1, 16'h0009, 16'h0100);
        bus_write(1'b0, 1'b1, 16'h000B, 16'h0007);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) step();
            tests++;
            if (addr_a !== exp_clr[i] || sync_pulse !== 1'b0) begin
                $display("FAIL clear_commit[%0d]: addr=%0d sync=%b, required %0d/0",
                         i, addr_a, sync_pulse, exp_clr[i]);
                fails++;
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 122; i++) step();
        tests++;
        if (addr_a !== 10'd500) begin
            $display("FAIL mid_reach: addr=%0d, required 500", addr_a);
            fails++;
        end
        #2;
        RST = 1'b1;
        #1;
        tests++;
        if (addr_a !== 10'd0 || phase_valid !== 1'b0 || sync_pulse !== 1'b0) begin
            $display("FAIL mid_reset_async: addr=%0d pv=%b sync=%b, required 0/0/0", addr_a, phase_valid, sync_pulse);
            fails++;
        end
        step();
        RST = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            tests++;
            if (addr_a !== 10'd0 || phase_valid !== 1'b0) begin
                $display("FAIL post_reset_hold[%0d]: addr=%0d pv=%b, required 0/0", i, addr_a, phase_valid);
                fails++;
            end
        end
        bus_write(1'b0, 1'b1, 16'h000B, 16'h0001);
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            tests++;
            if (addr_a !== 10'd0 || phase_valid !== 1'b1 || sync_pulse !== 1'b0) begin
                $display("FAIL zero_ftw_run[%0d]: addr=%0d pv=%b sync=%b, required 0/1/0",
                         i, addr_a, phase_valid, sync_pulse);
                fails++;
            end
        end
        bus_write(1'b0, 1'b1, 16'h0009, 16'h0040);
        bus_write(1'b0, 1'b1, 16'h000B, 16'h0003);
        step();
        step();
        tests++;
        if (addr_a !== 10'd0) begin
            $display("FAIL restart_hold: addr=%0d, required 0", addr_a);
            fails++;
        end
        step();
        tests++;
        if (addr_a !== 10'd1) begin
            $display("FAIL restart_first: addr=%0d, required 1", addr_a);
            fails++;
        end
    endtask

    task automatic test_ignored();
        bus_write(1'b1, 1'b1, 16'h0009, 16'h0200);
        tests++;
        if (addr_a !== 10'd2) begin
            $display("FAIL ign_cs_high: addr=%0d, required 2", addr_a);
            fails++;
        end
        bus_write(1'b0, 1'b1, 16'h000C, 16'hFFFF);
        tests++;
        if (addr_a !== 10'd3) begin
            $display("FAIL ign_unmapped: addr=%0d, required 3", addr_a);
            fails++;
        end
        bus_write(1'b0, 1'b0, 16'h0009, 16'h0300);
        bus_write(1'b1, 1'b1, 16'h000B, 16'h0004);
        bus_write(1'b0, 1'b1, 16'h000B, 16'h0003);
        tests++;
        if (addr_a !== 10'd6) begin
            $display("FAIL ign_commit: addr=%0d, required 6", addr_a);
            fails++;
        end
        for (int i = 7; i <= 12; i++) begin
            step();
            tests++;
            if (addr_a !== 10'(i) || phase_valid !== 1'b1) begin
                $display("FAIL ign_traj[%0d]: addr=%0d pv=%b, required %0d/1", i, addr_a, phase_valid, i);
                fails++;
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_count();
        test_commit();
        test_offset_idle();
        test_clear();
        test_reset_mid();
        test_ignored();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
